// File: rtl/systolic_ctrl.sv
// systolic_ctrl: latches A/B, clears the PE array, feeds skewed rows/columns
// for 3N-2 cycles, then captures the accumulators and pulses done.
module systolic_ctrl #(
    parameter int N = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N*N*WIDTH-1:0]     a_mat,
    input  logic [N*N*WIDTH-1:0]     b_mat,
    input  logic [N*N*2*WIDTH-1:0]   arr_c,
    output logic                     arr_clear,
    output logic [N*WIDTH-1:0]       a_feed,
    output logic [N*WIDTH-1:0]       b_feed,
    output logic                     busy,
    output logic                     done,
    output logic [N*N*2*WIDTH-1:0]   result
);
    localparam int TW = $clog2(3 * N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, CAPTURE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [TW-1:0]            t_q;
    logic [N*N*WIDTH-1:0]     a_q, b_q;
    logic [N*N*2*WIDTH-1:0]   result_q;
    logic                     busy_q, done_q, clear_q;

    // abort outranks every other transition but is meaningless in IDLE
    always_comb begin
        state_d = (state_q != IDLE && abort) ? IDLE :
                  state_q == IDLE            ? (start ? CLEAR : IDLE) :
                  state_q == CLEAR           ? FEED :
                  state_q == FEED            ? (t_q == T_LAST ? CAPTURE : FEED) :
                  state_q == CAPTURE         ? DONE : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= (state_q == FEED && state_d == FEED) ? t_q + 1'b1 : '0;
            busy_q  <= state_d != IDLE;
            clear_q <= state_d == CLEAR;
            done_q  <= state_d == DONE;
            if (state_q == IDLE && start) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
            if (state_q == CAPTURE && state_d == DONE)
                result_q <= arr_c;
        end
    end

    // row i carries A[i][t-i], column j carries B[t-j][j]; k is the shared inner index
    always_comb begin
        a_feed = '0;
        b_feed = '0;
        if (state_q == FEED)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < N; k++)
                    if (int'(t_q) == i + k) begin
                        a_feed[i*WIDTH +: WIDTH] = a_q[(i*N+k)*WIDTH +: WIDTH];
                        b_feed[i*WIDTH +: WIDTH] = b_q[(k*N+i)*WIDTH +: WIDTH];
                    end
    end

    assign arr_clear = clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed checks of the controller driving a behavioural PE array;
// a second instance with 9-bit operands exercises the full-width accumulator path.
module tb_systolic_ctrl;
    localparam int N = 2;
    localparam int W = 8;
    localparam int V = 9;
    localparam logic [63:0] R1 = 64'h0032_002B_0016_0013;
    localparam logic [63:0] R5 = 64'h0008_0006_0008_0006;

    logic clk = 1'b0;
    logic rst, start, abort, start9, abort9;
    logic [N*N*W-1:0]   a_mat, b_mat;
    logic [N*N*V-1:0]   a9, b9;
    logic [N*N*2*W-1:0] arr_c, result;
    logic [N*N*2*V-1:0] arr_c9, result9;
    logic [N*W-1:0]     a_feed, b_feed;
    logic [N*V-1:0]     a_feed9, b_feed9;
    logic arr_clear, busy, done, clr9, busy9, done9;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int dcnt0;
    logic [20:0] clr_m, done_m, idle_m;

    logic [V-1:0]  ain[2][N][N], bin[2][N][N], pa[2][N][N], pb[2][N][N];
    logic [31:0]   acc[2][N][N];

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .a_mat(a_mat), .b_mat(b_mat),
        .arr_c(arr_c), .arr_clear(arr_clear), .a_feed(a_feed), .b_feed(b_feed),
        .busy(busy), .done(done), .result(result)
    );

    systolic_ctrl #(.N(N), .WIDTH(V)) dut9 (
        .clk(clk), .rst(rst), .start(start9), .abort(abort9), .a_mat(a9), .b_mat(b9),
        .arr_c(arr_c9), .arr_clear(clr9), .a_feed(a_feed9), .b_feed(b_feed9),
        .busy(busy9), .done(done9), .result(result9)
    );

    // behavioural PE grid: a moves right, b moves down, each PE accumulates a*b
    always_comb begin
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < N; i++) begin
                ain[u][i][0] = u == 1 ? a_feed9[i*V +: V] : V'(a_feed[i*W +: W]);
                bin[u][0][i] = u == 1 ? b_feed9[i*V +: V] : V'(b_feed[i*W +: W]);
                for (int j = 1; j < N; j++) begin
                    ain[u][i][j] = pa[u][i][j-1];
                    bin[u][j][i] = pb[u][j-1][i];
                end
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (rst || (u == 0 ? arr_clear : clr9)) begin
                        acc[u][i][j] <= '0;
                        pa[u][i][j]  <= '0;
                        pb[u][i][j]  <= '0;
                    end else begin
                        acc[u][i][j] <= acc[u][i][j] + 32'(ain[u][i][j]) * 32'(bin[u][i][j]);
                        pa[u][i][j]  <= ain[u][i][j];
                        pb[u][i][j]  <= bin[u][i][j];
                    end
    end

    always_comb begin
        arr_c  = '0;
        arr_c9 = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                arr_c[(i*N+j)*2*W +: 2*W]  = acc[0][i][j][2*W-1:0];
                arr_c9[(i*N+j)*2*V +: 2*V] = acc[1][i][j][2*V-1:0];
            end
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start9 = 1'b0; abort9 = 1'b0;
        a_mat = '0; b_mat = '0; a9 = '0; b9 = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clear", arr_clear, 0);
        chk("rst_feed", {a_feed, b_feed}, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        // basic 2x2 job; operands scrambled right after the start edge
        a_mat = 32'h04030201; b_mat = 32'h08070605; start = 1'b1;
        step();
        start = 1'b0; a_mat = '1; b_mat = '1;
        chk("clear", arr_clear, 1);
        chk("clear_busy", busy, 1);
        chk("clear_feed", {a_feed, b_feed}, 0);
        step();
        chk("t0_a", a_feed, 16'h0001);
        chk("t0_b", b_feed, 16'h0005);
        chk("t0_clear", arr_clear, 0);
        step();
        chk("t1_a", a_feed, 16'h0302);
        chk("t1_b", b_feed, 16'h0607);
        step();
        chk("t2_a", a_feed, 16'h0400);
        chk("t2_b", b_feed, 16'h0800);
        step();
        chk("t3_feed", {a_feed, b_feed}, 0);
        chk("t3_done", done, 0);
        step();
        chk("capture_done", done, 0);
        chk("capture_feed", {a_feed, b_feed}, 0);
        step();
        chk("done", done, 1);
        chk("result1", result, R1);
        step();
        chk("done_fall", done, 0);
        chk("idle_busy", busy, 0);
        // full-scale operands on the 9-bit instance
        a9 = {4{9'd255}}; b9 = {4{9'd255}}; start9 = 1'b1;
        step();
        start9 = 1'b0;
        repeat (6) step();
        chk("done9", done9, 1);
        chk("result9", result9, {4{18'h1FC02}});
        chk("hold1", result, R1);
        step();
        // abort in IDLE, then start+abort together
        abort = 1'b1;
        step();
        chk("abort_idle", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_abort", arr_clear, 1);
        step();
        abort = 1'b0;
        chk("abort_clear", busy, 0);
        // abort during FEED at t=1
        dcnt0 = done_cnt;
        a_mat = 32'h01010101; b_mat = 32'h05040302; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_t1_a", a_feed, 16'h0101);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_feed", {a_feed, b_feed}, 0);
        repeat (8) step();
        chk("abort_nodone", done_cnt, dcnt0);
        chk("abort_result", result, R1);
        // start held high: one IDLE cycle between jobs
        a_mat = 32'h04030201; b_mat = 32'h08070605; start = 1'b1;
        clr_m = '0; done_m = '0; idle_m = '0;
        for (int k = 1; k <= 20; k++) begin
            step();
            clr_m[k]  = arr_clear;
            done_m[k] = done;
            idle_m[k] = !busy;
        end
        start = 1'b0;
        chk("held_clear", clr_m, 21'h020202);
        chk("held_done", done_m, 21'h008080);
        chk("held_idle_gap", idle_m, 21'h010100);
        repeat (5) step();
        chk("held_end", busy, 0);
        chk("held_result", result, R1);
        // reset in the middle of FEED
        a_mat = 32'h01010101; b_mat = 32'h05040302; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        dcnt0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_clear", arr_clear, 0);
        chk("mid_rst_feed", {a_feed, b_feed}, 0);
        chk("mid_rst_result", result, 0);
        step();
        rst = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("restart", arr_clear, 1);
        repeat (6) step();
        chk("rst_nodone", done_cnt, dcnt0);
        chk("rerun_done", done, 1);
        chk("rerun_result", result, R5);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
